// File: rtl/stereo_column_feeder.sv
// -----------------------------------------------------------------------------
// stereo_column_feeder
//
// Front end of the SAD disparity block. Buffers the most recent KERNEL_WIDTH
// rows of the left and right pixel streams in rotating line-buffer banks,
// builds a vertical KERNEL_WIDTH-pixel column per camera for every accepted
// pixel from row KERNEL_WIDTH-1 onward, queues the columns in a FIFO and
// hands them to the SAD stage one at a time.
//
// Ports:
//   clk_in            single system clock
//   rst_in            synchronous, active-high reset
//   left_pixel_in     left camera pixel (8 bit grayscale)
//   right_pixel_in    right camera pixel at the same coordinate
//   hcount_in         pixel column of the incoming pair
//   vcount_in         pixel row of the incoming pair
//   pixel_valid_in    incoming pair is valid this cycle
//   sad_busy_in       SAD stage cannot take a column while high
//   left_column_out   left column, index 0 = oldest (top) row
//   right_column_out  right column, same ordering
//   hcount_out        x coordinate of the presented column
//   vcount_out        y coordinate of the column's centre row
//   column_valid_out  one-cycle pulse: column presented to SAD
//   fifo_count_out    number of queued columns
//   overflow_out      sticky: a column was dropped on a full FIFO
//
// Pipeline: pixel registered at E0, bank write + bank read at E1, column
// pushed into the FIFO at E2, earliest issue at E3.
// -----------------------------------------------------------------------------
module stereo_column_feeder #(
    parameter int KERNEL_WIDTH = 3,
    parameter int H_ACTIVE     = 320,
    parameter int V_ACTIVE     = 240,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic                               clk_in,
    input  logic                               rst_in,
    input  logic [7:0]                         left_pixel_in,
    input  logic [7:0]                         right_pixel_in,
    input  logic [10:0]                        hcount_in,
    input  logic [9:0]                         vcount_in,
    input  logic                               pixel_valid_in,
    input  logic                               sad_busy_in,
    output logic [KERNEL_WIDTH-1:0][7:0]       left_column_out,
    output logic [KERNEL_WIDTH-1:0][7:0]       right_column_out,
    output logic [10:0]                        hcount_out,
    output logic [9:0]                         vcount_out,
    output logic                               column_valid_out,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_count_out,
    output logic                               overflow_out
);

    localparam int BANK_W = (KERNEL_WIDTH > 1) ? $clog2(KERNEL_WIDTH) : 1;
    localparam int ADDR_W = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
    localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);

    localparam logic [10:0]      H_LAST     = 11'(H_ACTIVE - 1);
    localparam logic [10:0]      H_LIMIT    = 11'(H_ACTIVE);
    localparam logic [9:0]       V_LIMIT    = 10'(V_ACTIVE);
    localparam logic [9:0]       V_FIRST    = 10'(KERNEL_WIDTH - 1);
    localparam logic [9:0]       V_CENTRE   = 10'(KERNEL_WIDTH / 2);
    localparam logic [CNT_W-1:0] CNT_FULL   = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};
    localparam logic [BANK_W-1:0] BANK_ZERO = {BANK_W{1'b0}};

    // Bank arithmetic modulo KERNEL_WIDTH (banks rotate one per line).
    function automatic logic [BANK_W-1:0] bank_add(input logic [BANK_W-1:0] base,
                                                   input int off);
        int sum;
        sum = (int'(base) + off) % KERNEL_WIDTH;
        return BANK_W'(sum);
    endfunction

    // ------------------------------------------------------------------
    // Stage 0: accepted pixel register
    // ------------------------------------------------------------------
    logic        accept_s;
    logic        s0_valid_r;
    logic [7:0]  s0_left_r;
    logic [7:0]  s0_right_r;
    logic [10:0] s0_h_r;
    logic [9:0]  s0_v_r;

    // Only in-window pixels enter the pipeline
    always_comb begin
        if (pixel_valid_in && (hcount_in < H_LIMIT) && (vcount_in < V_LIMIT)) begin
            accept_s = 1'b1;
        end else begin
            accept_s = 1'b0;
        end
    end

    // Capture the incoming pair; payload needs no reset, the valid flag does
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            s0_valid_r <= 1'b0;
        end else begin
            s0_valid_r <= accept_s;
        end
        s0_left_r  <= left_pixel_in;
        s0_right_r <= right_pixel_in;
        s0_h_r     <= hcount_in;
        s0_v_r     <= vcount_in;
    end

    // ------------------------------------------------------------------
    // Stage 1: bank select, line-buffer write and read
    // ------------------------------------------------------------------
    logic [BANK_W-1:0] wr_bank_r;
    logic [BANK_W-1:0] used_bank_s;
    logic [ADDR_W-1:0] lb_addr_s;

    assign lb_addr_s = s0_h_r[ADDR_W-1:0];

    // Frame origin always lands in bank 0 so a restarted frame realigns
    always_comb begin
        if ((s0_h_r == 11'd0) && (s0_v_r == 10'd0)) begin
            used_bank_s = BANK_ZERO;
        end else begin
            used_bank_s = wr_bank_r;
        end
    end

    // Rotate to the next bank after the last pixel of a line
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            wr_bank_r <= BANK_ZERO;
        end else if (s0_valid_r) begin
            if (s0_h_r == H_LAST) begin
                wr_bank_r <= bank_add(used_bank_s, 32'sd1);
            end else begin
                wr_bank_r <= used_bank_s;
            end
        end
    end

    logic [7:0] left_rd_s  [KERNEL_WIDTH];
    logic [7:0] right_rd_s [KERNEL_WIDTH];

    for (genvar b = 0; b < KERNEL_WIDTH; b++) begin : g_bank
        logic [7:0] left_mem  [H_ACTIVE];
        logic [7:0] right_mem [H_ACTIVE];
        logic [7:0] left_rd_r;
        logic [7:0] right_rd_r;

        // Write port: only the bank holding the current line takes the pixel
        always_ff @(posedge clk_in) begin
            if (s0_valid_r && (used_bank_s == BANK_W'(b))) begin
                left_mem[lb_addr_s]  <= s0_left_r;
                right_mem[lb_addr_s] <= s0_right_r;
            end
        end

        // Read port: registered read, one-cycle latency (BRAM style)
        always_ff @(posedge clk_in) begin
            if (s0_valid_r) begin
                left_rd_r  <= left_mem[lb_addr_s];
                right_rd_r <= right_mem[lb_addr_s];
            end
        end

        assign left_rd_s[b]  = left_rd_r;
        assign right_rd_s[b] = right_rd_r;
    end

    logic              s1_valid_r;
    logic [BANK_W-1:0] s1_bank_r;
    logic [7:0]        s1_left_r;
    logic [7:0]        s1_right_r;
    logic [10:0]       s1_h_r;
    logic [9:0]        s1_v_r;

    // Carry the live pixel and column metadata alongside the bank read
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            s1_valid_r <= 1'b0;
        end else begin
            s1_valid_r <= s0_valid_r && (s0_v_r >= V_FIRST);
        end
        s1_bank_r  <= used_bank_s;
        s1_left_r  <= s0_left_r;
        s1_right_r <= s0_right_r;
        s1_h_r     <= s0_h_r;
        s1_v_r     <= s0_v_r - V_CENTRE;
    end

    // ------------------------------------------------------------------
    // Stage 2: column assembly
    // ------------------------------------------------------------------
    logic [KERNEL_WIDTH-1:0][7:0] cand_left_s;
    logic [KERNEL_WIDTH-1:0][7:0] cand_right_s;

    // Oldest row sits in the bank just after the live one (mod KERNEL_WIDTH)
    always_comb begin
        cand_left_s  = {KERNEL_WIDTH{8'h00}};
        cand_right_s = {KERNEL_WIDTH{8'h00}};
        for (int i = 0; i < KERNEL_WIDTH - 1; i++) begin
            cand_left_s[i]  = left_rd_s[bank_add(s1_bank_r, i + 32'sd1)];
            cand_right_s[i] = right_rd_s[bank_add(s1_bank_r, i + 32'sd1)];
        end
        cand_left_s[KERNEL_WIDTH-1]  = s1_left_r;
        cand_right_s[KERNEL_WIDTH-1] = s1_right_r;
    end

    // ------------------------------------------------------------------
    // Column FIFO and issue
    // ------------------------------------------------------------------
    logic [KERNEL_WIDTH-1:0][7:0] fifo_left_r  [FIFO_DEPTH];
    logic [KERNEL_WIDTH-1:0][7:0] fifo_right_r [FIFO_DEPTH];
    logic [10:0]                  fifo_h_r     [FIFO_DEPTH];
    logic [9:0]                   fifo_v_r     [FIFO_DEPTH];

    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic [CNT_W-1:0] count_next_s;
    logic             overflow_r;
    logic             valid_r;
    logic             pop_s;
    logic             push_ok_s;
    logic             drop_s;

    // Issue only between pulses so SAD has a cycle to raise busy
    always_comb begin
        if ((count_r != CNT_ZERO) && !sad_busy_in && !valid_r) begin
            pop_s = 1'b1;
        end else begin
            pop_s = 1'b0;
        end
    end

    // A full FIFO still accepts a push when a pop frees a slot in the same cycle
    always_comb begin
        if (s1_valid_r && ((count_r != CNT_FULL) || pop_s)) begin
            push_ok_s = 1'b1;
            drop_s    = 1'b0;
        end else if (s1_valid_r) begin
            push_ok_s = 1'b0;
            drop_s    = 1'b1;
        end else begin
            push_ok_s = 1'b0;
            drop_s    = 1'b0;
        end
    end

    // Occupancy bookkeeping
    always_comb begin
        case ({push_ok_s, pop_s})
            2'b10:   count_next_s = count_r + CNT_W'(1);
            2'b01:   count_next_s = count_r - CNT_W'(1);
            default: count_next_s = count_r;
        endcase
    end

    // FIFO storage write (no reset: contents are qualified by the count)
    always_ff @(posedge clk_in) begin
        if (push_ok_s) begin
            fifo_left_r[wr_ptr_r]  <= cand_left_s;
            fifo_right_r[wr_ptr_r] <= cand_right_s;
            fifo_h_r[wr_ptr_r]     <= s1_h_r;
            fifo_v_r[wr_ptr_r]     <= s1_v_r;
        end
    end

    // Pointers, count and sticky overflow
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            wr_ptr_r   <= {PTR_W{1'b0}};
            rd_ptr_r   <= {PTR_W{1'b0}};
            count_r    <= CNT_ZERO;
            overflow_r <= 1'b0;
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            count_r <= count_next_s;
            if (drop_s) begin
                overflow_r <= 1'b1;
            end
        end
    end

    // Output registers load on a pop and hold otherwise
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            valid_r          <= 1'b0;
            left_column_out  <= {KERNEL_WIDTH{8'h00}};
            right_column_out <= {KERNEL_WIDTH{8'h00}};
            hcount_out       <= 11'd0;
            vcount_out       <= 10'd0;
        end else begin
            valid_r <= pop_s;
            if (pop_s) begin
                left_column_out  <= fifo_left_r[rd_ptr_r];
                right_column_out <= fifo_right_r[rd_ptr_r];
                hcount_out       <= fifo_h_r[rd_ptr_r];
                vcount_out       <= fifo_v_r[rd_ptr_r];
            end
        end
    end

    assign column_valid_out = valid_r;
    assign fifo_count_out   = count_r;
    assign overflow_out     = overflow_r;

endmodule

// File: tb/tb_stereo_column_feeder.sv
// -----------------------------------------------------------------------------
// Self-checking bench for stereo_column_feeder. A behavioural model keeps the
// line buffers as plain arrays, tracks the FIFO as a queue and decides each
// cycle whether a column issues; issued columns go to a scoreboard queue that
// a negedge monitor compares against whatever the DUT presents.
// -----------------------------------------------------------------------------
module tb_stereo_column_feeder;

    localparam int K = 3;
    localparam int H = 320;
    localparam int V = 240;
    localparam int D = 16;

    logic clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    logic                   rst_in;
    logic [7:0]             left_pixel_in;
    logic [7:0]             right_pixel_in;
    logic [10:0]            hcount_in;
    logic [9:0]             vcount_in;
    logic                   pixel_valid_in;
    logic                   sad_busy_in;
    logic [K-1:0][7:0]      left_column_out;
    logic [K-1:0][7:0]      right_column_out;
    logic [10:0]            hcount_out;
    logic [9:0]             vcount_out;
    logic                   column_valid_out;
    logic [$clog2(D+1)-1:0] fifo_count_out;
    logic                   overflow_out;

    logic busy_manual = 1'b0;
    logic busy_auto   = 1'b0;
    logic sad_mode    = 1'b0;
    assign sad_busy_in = sad_mode ? busy_auto : busy_manual;

    stereo_column_feeder #(
        .KERNEL_WIDTH(K), .H_ACTIVE(H), .V_ACTIVE(V), .FIFO_DEPTH(D)
    ) dut (
        .clk_in(clk_in), .rst_in(rst_in),
        .left_pixel_in(left_pixel_in), .right_pixel_in(right_pixel_in),
        .hcount_in(hcount_in), .vcount_in(vcount_in),
        .pixel_valid_in(pixel_valid_in), .sad_busy_in(sad_busy_in),
        .left_column_out(left_column_out), .right_column_out(right_column_out),
        .hcount_out(hcount_out), .vcount_out(vcount_out),
        .column_valid_out(column_valid_out), .fifo_count_out(fifo_count_out),
        .overflow_out(overflow_out)
    );

    typedef struct {
        logic [K-1:0][7:0] l;
        logic [K-1:0][7:0] r;
        int                h;
        int                v;
    } col_t;

    col_t mq[$];      // model FIFO contents
    col_t exp_q[$];   // scoreboard: columns the DUT must present, in order
    col_t d1, d2;
    bit   d1_v = 1'b0, d2_v = 1'b0;
    logic [7:0] bank_l [K][H];
    logic [7:0] bank_r [K][H];
    int   wr_bank_m = 0;
    bit   valid_m = 1'b0, overflow_m = 1'b0, busy_at_edge = 1'b0;
    bit   checking = 1'b0, prev_valid = 1'b0;
    int   busy_cnt = 0;
    int   n_valid = 0;
    int   n_cmp = 0, n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: line buffers, FIFO occupancy and issue decision
    always @(posedge clk_in) begin
        col_t c;
        col_t pc;
        bit   pop;
        bit   pv;
        int   used;
        int   hh;
        int   vv;
        busy_at_edge = sad_busy_in;
        if (rst_in) begin
            mq.delete();
            exp_q.delete();
            d1_v = 1'b0; d2_v = 1'b0;
            valid_m = 1'b0; overflow_m = 1'b0; wr_bank_m = 0;
        end else begin
            pop = (mq.size() > 0) && !sad_busy_in && !valid_m;
            pv = d2_v; pc = d2;
            d2_v = d1_v; d2 = d1;
            d1_v = 1'b0;
            if (pixel_valid_in && hcount_in < H && vcount_in < V) begin
                hh = int'(hcount_in);
                vv = int'(vcount_in);
                used = (hh == 0 && vv == 0) ? 0 : wr_bank_m;
                for (int i = 0; i < K - 1; i++) begin
                    c.l[i] = bank_l[(used - (K - 1) + i + K) % K][hh];
                    c.r[i] = bank_r[(used - (K - 1) + i + K) % K][hh];
                end
                c.l[K-1] = left_pixel_in;
                c.r[K-1] = right_pixel_in;
                c.h = hh;
                c.v = vv - K / 2;
                bank_l[used][hh] = left_pixel_in;
                bank_r[used][hh] = right_pixel_in;
                wr_bank_m = (hh == H - 1) ? (used + 1) % K : used;
                if (vv >= K - 1) begin
                    d1 = c;
                    d1_v = 1'b1;
                end
            end
            if (pop) begin
                exp_q.push_back(mq.pop_front());
                valid_m = 1'b1;
            end else begin
                valid_m = 1'b0;
            end
            if (pv) begin
                if (mq.size() < D) mq.push_back(pc);
                else overflow_m = 1'b1;
            end
        end
    end

    // Monitor: compare DUT against the model away from the active edge; SAD busy model
    always @(negedge clk_in) begin
        col_t e;
        if (checking) begin
            chk("valid", column_valid_out, valid_m);
            chk("count", fifo_count_out, mq.size());
            chk("overflow", overflow_out, overflow_m);
            if (column_valid_out === 1'b1) begin
                n_valid++;
                chk("back_to_back", prev_valid, 0);
                chk("busy_at_issue", busy_at_edge, 0);
                if (exp_q.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL unexpected_column: got h=%0d v=%0d expected none", hcount_out, vcount_out);
                end else begin
                    e = exp_q.pop_front();
                    chk("left_col", left_column_out, e.l);
                    chk("right_col", right_column_out, e.r);
                    chk("hcount_out", hcount_out, e.h);
                    chk("vcount_out", vcount_out, e.v);
                end
            end
            prev_valid = (column_valid_out === 1'b1);
        end
        if (column_valid_out === 1'b1) busy_cnt = 22;
        else if (busy_cnt > 0) busy_cnt--;
        busy_auto = (busy_cnt > 0);
    end

    task automatic px(input int h, input int v, input bit rnd);
        @(negedge clk_in);
        hcount_in = 11'(h);
        vcount_in = 10'(v);
        pixel_valid_in = 1'b1;
        if (rnd) begin
            left_pixel_in  = 8'($urandom);
            right_pixel_in = 8'($urandom);
        end else begin
            left_pixel_in  = 8'(h + v);
            right_pixel_in = 8'(h + v + 1);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk_in);
            pixel_valid_in = 1'b0;
        end
    endtask

    task automatic drain(input int bound);
        int n = 0;
        while ((mq.size() != 0 || d1_v || d2_v || valid_m) && n < bound) begin
            idle(1);
            n++;
        end
        n_cmp++;
        if (n >= bound) begin
            n_bad++;
            $display("FAIL drain_timeout: got %0d cycles expected fewer than %0d", n, bound);
        end
        idle(2);
    endtask

    initial begin
        int base;
        rst_in = 1'b1;
        pixel_valid_in = 1'b0;
        hcount_in = 11'd0; vcount_in = 10'd0;
        left_pixel_in = 8'd0; right_pixel_in = 8'd0;
        repeat (3) @(negedge clk_in);
        rst_in = 1'b0;
        checking = 1'b1;
        chk("rst_valid", column_valid_out, 0);
        chk("rst_count", fifo_count_out, 0);
        chk("rst_overflow", overflow_out, 0);
        chk("rst_hcount", hcount_out, 0);
        chk("rst_left", left_column_out, 0);

        // Rows 0-1 then (5,2): first column and minimum latency
        base = n_valid;
        for (int v = 0; v < 2; v++)
            for (int h = 0; h < H; h++) px(h, v, 1'b0);
        px(5, 2, 1'b0);
        idle(3);
        chk("t1_no_early", column_valid_out, 0);
        chk("t1_rows01_silent", n_valid - base, 0);
        idle(1);
        chk("t1_valid", column_valid_out, 1);
        chk("t1_left", left_column_out, 24'h070605);
        chk("t1_right", right_column_out, 24'h080706);
        chk("t1_h", hcount_out, 5);
        chk("t1_v", vcount_out, 1);

        // Fill the FIFO while busy, then overflow
        busy_manual = 1'b1;
        for (int h = 0; h < 16; h++) px(h, 2, 1'b0);
        idle(3);
        chk("t2_full_count", fifo_count_out, 16);
        chk("t2_no_overflow", overflow_out, 0);
        px(16, 2, 1'b0);
        idle(3);
        chk("t2_count_held", fifo_count_out, 16);
        chk("t2_overflow", overflow_out, 1);
        base = n_valid;
        busy_manual = 1'b0;
        drain(200);
        chk("t2_issued", n_valid - base, 16);

        // SAD model with 22-cycle busy, full row streamed back-to-back
        sad_mode = 1'b1;
        for (int h = 0; h < H; h++) px(h, 2, 1'b1);
        idle(1);
        drain(20000);
        idle(25);
        sad_mode = 1'b0;

        // Out-of-window pixels, then row 3 paced at one pixel per two cycles
        base = n_valid;
        for (int h = H; h < 400; h++) px(h, 2, 1'b1);
        for (int h = 0; h < 10; h++) px(h, 245, 1'b1);
        idle(4);
        chk("t4_oow_count", fifo_count_out, 0);
        chk("t4_oow_silent", n_valid - base, 0);
        for (int h = 0; h < H; h++) begin
            px(h, 3, 1'b1);
            idle(1);
        end
        drain(200);
        chk("t4_row3_issued", n_valid - base, H);

        // Abort mid-frame at v=100 and restart at the origin
        for (int h = 0; h < 41; h++) begin
            px(h, 100, 1'b1);
            idle(1);
        end
        drain(200);
        base = n_valid;
        for (int v = 0; v < 2; v++)
            for (int h = 0; h < H; h++) px(h, v, 1'b1);
        idle(4);
        chk("t5_new_rows01_silent", n_valid - base, 0);
        for (int h = 0; h < 20; h++) begin
            px(h, 2, 1'b1);
            idle(1);
        end
        drain(200);
        chk("t5_row2_issued", n_valid - base, 20);

        // Reset with a partly full FIFO and a candidate in flight
        busy_manual = 1'b1;
        for (int h = 20; h < 25; h++) px(h, 2, 1'b1);
        idle(3);
        chk("t6_count5", fifo_count_out, 5);
        chk("t6_overflow_sticky", overflow_out, 1);
        px(25, 2, 1'b1);
        @(negedge clk_in);
        rst_in = 1'b1;
        pixel_valid_in = 1'b0;
        @(negedge clk_in);
        rst_in = 1'b0;
        chk("t6_rst_count", fifo_count_out, 0);
        chk("t6_rst_valid", column_valid_out, 0);
        chk("t6_rst_overflow", overflow_out, 0);
        busy_manual = 1'b0;
        base = n_valid;
        idle(40);
        chk("t6_no_stale", n_valid - base, 0);

        chk("leftover_expected", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/stereo_column_feeder.md
Name: stereo_column_feeder

Overview:
Upstream stage of the SAD disparity block. Takes synchronised left/right 8-bit grayscale pixel streams and buffers the last KERNEL_WIDTH rows of each camera in line buffers. Assembles vertical KERNEL_WIDTH-pixel columns per camera and queues them in a FIFO. Releases one column at a time to the SAD stage, honouring its busy signal.

Parameters:
KERNEL_WIDTH, 3, rows per column; must match the SAD kernel width.
H_ACTIVE, 320, active pixels per line.
V_ACTIVE, 240, active lines per frame.
FIFO_DEPTH, 16, column entries buffered (power of two).

Ports:
clk_in  input  1  system clock; the block uses this single clock.
rst_in  input  1  synchronous, active-high reset.
left_pixel_in  input  8  left camera grayscale pixel.
right_pixel_in  input  8  right camera grayscale pixel, same coordinate as left.
hcount_in  input  11  pixel column.
vcount_in  input  10  pixel row.
pixel_valid_in  input  1  pixel pair valid this cycle.
sad_busy_in  input  1  SAD stage busy; no column may be issued while high.
left_column_out  output  [KERNEL_WIDTH-1:0][7:0]  left column; index 0 = top (oldest) row.
right_column_out  output  [KERNEL_WIDTH-1:0][7:0]  right column, same ordering.
hcount_out  output  11  column x coordinate.
vcount_out  output  10  column centre-row y coordinate.
column_valid_out  output  1  one-cycle pulse: column presented to SAD.
fifo_count_out  output  $clog2(FIFO_DEPTH+1)  entries currently queued.
overflow_out  output  1  sticky: a column was dropped because the FIFO was full.

Behaviour:
- Reset: all outputs 0, FIFO empty, write-bank pointer 0. Line buffer contents are not cleared; they are don't-care.
- Acceptance: a pixel is accepted iff pixel_valid_in && hcount_in < H_ACTIVE && vcount_in < V_ACTIVE. Otherwise nothing is written and nothing is queued.
- Line buffers: KERNEL_WIDTH banks per camera, each H_ACTIVE x 8, inferred BRAM, 1-cycle read latency.
- Bank select: used_bank = 0 if (hcount_in==0 && vcount_in==0), else wr_bank. The accepted pixel is written to used_bank at address hcount_in.
- Bank advance: if hcount_in==H_ACTIVE-1, wr_bank <= (used_bank+1) mod KERNEL_WIDTH; otherwise wr_bank <= used_bank.
- Column assembly: element i (0..KERNEL_WIDTH-2) is read from bank (used_bank-(KERNEL_WIDTH-1)+i) mod KERNEL_WIDTH at hcount_in. Element KERNEL_WIDTH-1 is the live pixel, delayed to align with the read.
- Column qualification: a column is produced only when vcount_in >= KERNEL_WIDTH-1. Coordinates are hcount_in and vcount_in-KERNEL_WIDTH/2.
- Pipeline: pixel sampled at edge E0; bank read data valid after E1; the candidate is written into the FIFO at E2.
- FIFO push when full: if no pop in the same cycle, the entry is dropped, overflow_out <= 1 (held until reset) and the count is unchanged.
- Simultaneous push and pop: both succeed and the count is unchanged, including when full. Push when empty with no pop: count becomes 1.
- Issue rule: pop when FIFO non-empty && !sad_busy_in && !column_valid_out. The output registers load at that edge and column_valid_out is high for exactly the next cycle. Valid pulses are therefore never back-to-back, which covers SAD raising busy one cycle after acceptance.
- Output hold: outputs keep their last values while column_valid_out is low.
- Minimum latency: 3 cycles, from pixel accept edge E0 to column_valid_out high after E3 (FIFO empty, SAD idle).
- Ordering: strictly FIFO, in raster order.
- Reset mid-operation: the next cycle shows count 0, valid 0, overflow 0. In-flight pipeline candidates are discarded.

Test Plan:
- Rows 0-1 fully fed, then pixel (h=5, v=2), with left=(h+v)[7:0] and right=left+1, busy low -> no valid during rows 0-1. column_valid_out goes high 3 cycles after the h=5 pixel with left_column_out={7,6,5} (idx2..0), right_column_out={8,7,6}, hcount_out=5, vcount_out=1.
- sad_busy_in high, h=0..15 of row 2 -> fifo_count_out=16, overflow_out=0. h=16 -> count stays 16, overflow_out=1. Release busy -> 16 columns emerge for h=0..15 in order, none for h=16.
- SAD model asserting busy 22 cycles after each valid, full row 2 streamed -> every valid pulse falls while busy is low, and no two valid pulses fall on adjacent cycles.
- Pixels with hcount_in=320..399 and pixel_valid_in=1 -> no FIFO change. Row 3 columns show row 2 data unchanged at h=0..319.
- Abort a frame at v=100, then restart at (0,0) -> no columns for v=0..1 of the new frame. Column (h=0, v=2) contains only new-frame rows 0..2.
- FIFO count 5, overflow_out=1, then rst_in pulsed one cycle -> next cycle count 0, valid 0, overflow 0. No stale column is issued afterwards.
